// File: rtl/write_to_ddr3.sv
// Frame writer: drains a show-ahead pixel FIFO into one of two DDR3 frame
// buffers as 4-beat Avalon bursts and ping-pongs between the two buffers.
// Optional macro WRITE_TEST_PORT_EN adds a single-beat test write port.
module write_to_ddr3 #(
  parameter int unsigned IMAGE_WIDTH  = 1280,
  parameter int unsigned IMAGE_HEIGHT = 1024
) (
  input  logic         ddr3_clk,
  input  logic         ddr3_reset_n,
  input  logic         frame_start,
  input  logic [127:0] data_fifo_rd_data,
  input  logic [8:0]   data_fifo_usedw,
  output logic         data_fifo_rd,
  input  logic [25:0]  ddr3_buffer0_offset,
  input  logic [25:0]  ddr3_buffer1_offset,
  input  logic         clear_buffer0,
  input  logic         clear_buffer1,
  output logic         buffer0_full,
  output logic         buffer1_full,
  input  logic         ddr3_avl_ready,
  output logic         ddr3_avl_burstbegin,
  output logic         ddr3_avl_write_req,
  output logic [2:0]   ddr3_avl_size,
  output logic [25:0]  ddr3_avl_addr,
  output logic [127:0] ddr3_avl_wdata,
  output logic [15:0]  ddr3_avl_be
`ifdef WRITE_TEST_PORT_EN
  ,
  input  logic         test_wr,
  input  logic [31:0]  test_addr,
  input  logic [127:0] test_wr_data,
  output logic         wr_finish
`endif
);

  localparam int unsigned LAST_BURST = ((IMAGE_WIDTH * IMAGE_HEIGHT) >> 2) - 1;
  localparam int unsigned BURST_W    = (LAST_BURST > 0) ? $clog2(LAST_BURST + 1) : 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_DATA   = 2'd1,
    WRITE_BURST = 2'd2
`ifdef WRITE_TEST_PORT_EN
    , TEST_WRITE = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [25:0]          addr_q, addr_d;
  logic [BURST_W-1:0]   burst_count_q, burst_count_d;
  logic [1:0]           beat_q, beat_d;
  logic                 buffer_sel_q, buffer_sel_d;
  logic                 buf0_full_q, buf0_full_d;
  logic                 buf1_full_q, buf1_full_d;
  logic                 write_req_q, write_req_d;
  logic                 burstbegin_q, burstbegin_d;
  logic [2:0]           size_q, size_d;
  logic [15:0]          be_q, be_d;
  logic                 accept;
  logic                 sel_full;

`ifdef WRITE_TEST_PORT_EN
  logic [127:0]         test_wdata_q, test_wdata_d;
  logic                 wr_finish_q, wr_finish_d;
  logic                 unused_test_addr;
  assign unused_test_addr = ^test_addr[31:26];
`endif

  assign accept   = write_req_q & ddr3_avl_ready;
  assign sel_full = buffer_sel_q ? buf1_full_q : buf0_full_q;

  // Next-state and next-output computation
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    burst_count_d = burst_count_q;
    beat_d        = beat_q;
    buffer_sel_d  = buffer_sel_q;
    buf0_full_d   = buf0_full_q & ~clear_buffer0;
    buf1_full_d   = buf1_full_q & ~clear_buffer1;
    write_req_d   = write_req_q;
    burstbegin_d  = burstbegin_q;
    size_d        = size_q;
    be_d          = be_q;
`ifdef WRITE_TEST_PORT_EN
    test_wdata_d  = test_wdata_q;
    wr_finish_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef WRITE_TEST_PORT_EN
        if (test_wr) begin
          state_d      = TEST_WRITE;
          addr_d       = test_addr[25:0];
          test_wdata_d = test_wr_data;
          write_req_d  = 1'b1;
          burstbegin_d = 1'b1;
          size_d       = 3'b001;
          be_d         = '1;
        end else
`endif
        if (frame_start && !sel_full) begin
          state_d       = WAIT_DATA;
          addr_d        = buffer_sel_q ? ddr3_buffer1_offset : ddr3_buffer0_offset;
          burst_count_d = '0;
          beat_d        = 2'd0;
        end
      end
      WAIT_DATA: begin
        if (data_fifo_usedw >= 9'd4) begin
          state_d      = WRITE_BURST;
          beat_d       = 2'd0;
          write_req_d  = 1'b1;
          burstbegin_d = 1'b1;
          size_d       = 3'b100;
          be_d         = '1;
        end
      end
      WRITE_BURST: begin
        if (accept) begin
          beat_d       = beat_q + 2'd1;
          burstbegin_d = 1'b0;
          if (beat_q == 2'd3) begin
            write_req_d = 1'b0;
            size_d      = 3'b000;
            be_d        = '0;
            if (burst_count_q == BURST_W'(LAST_BURST)) begin
              if (buffer_sel_q) buf1_full_d = 1'b1;
              else              buf0_full_d = 1'b1;
              buffer_sel_d = ~buffer_sel_q;
              state_d      = IDLE;
            end else begin
              addr_d        = addr_q + 26'd4;
              burst_count_d = burst_count_q + BURST_W'(1);
              state_d       = WAIT_DATA;
            end
          end
        end
      end
`ifdef WRITE_TEST_PORT_EN
      TEST_WRITE: begin
        if (accept) begin
          write_req_d  = 1'b0;
          burstbegin_d = 1'b0;
          size_d       = 3'b000;
          be_d         = '0;
          wr_finish_d  = 1'b1;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      burst_count_q <= '0;
      beat_q        <= 2'd0;
      buffer_sel_q  <= 1'b0;
      buf0_full_q   <= 1'b0;
      buf1_full_q   <= 1'b0;
      write_req_q   <= 1'b0;
      burstbegin_q  <= 1'b0;
      size_q        <= 3'b000;
      be_q          <= '0;
`ifdef WRITE_TEST_PORT_EN
      test_wdata_q  <= '0;
      wr_finish_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      burst_count_q <= burst_count_d;
      beat_q        <= beat_d;
      buffer_sel_q  <= buffer_sel_d;
      buf0_full_q   <= buf0_full_d;
      buf1_full_q   <= buf1_full_d;
      write_req_q   <= write_req_d;
      burstbegin_q  <= burstbegin_d;
      size_q        <= size_d;
      be_q          <= be_d;
`ifdef WRITE_TEST_PORT_EN
      test_wdata_q  <= test_wdata_d;
      wr_finish_q   <= wr_finish_d;
`endif
    end
  end

  // FIFO pop follows each accepted frame beat; write data is the FIFO head
  assign data_fifo_rd        = (state_q == WRITE_BURST) & accept;
`ifdef WRITE_TEST_PORT_EN
  assign ddr3_avl_wdata      = (state_q == TEST_WRITE) ? test_wdata_q : data_fifo_rd_data;
  assign wr_finish           = wr_finish_q;
`else
  assign ddr3_avl_wdata      = data_fifo_rd_data;
`endif
  assign ddr3_avl_write_req  = write_req_q;
  assign ddr3_avl_burstbegin = burstbegin_q;
  assign ddr3_avl_size       = size_q;
  assign ddr3_avl_addr       = addr_q;
  assign ddr3_avl_be         = be_q;
  assign buffer0_full        = buf0_full_q;
  assign buffer1_full        = buf1_full_q;

endmodule

// File: tb/tb_write_to_ddr3.sv
// Scoreboard bench for write_to_ddr3 with an 8x4 frame (8 bursts per frame).
module tb_write_to_ddr3;

  typedef struct {
    logic [25:0]  addr;
    logic [127:0] data;
    logic         bb;
    logic [2:0]   size;
    logic         pop;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_start = 1'b0;
  logic [127:0] fifo_data;
  logic [8:0]   usedw = 9'd16;
  logic         fifo_rd;
  logic [25:0]  off0 = 26'h100;
  logic [25:0]  off1 = 26'h200;
  logic         clr0 = 1'b0;
  logic         clr1 = 1'b0;
  logic         full0, full1;
  logic         ready = 1'b1;
  logic         bb, wreq;
  logic [2:0]   size;
  logic [25:0]  addr;
  logic [127:0] wdata;
  logic [15:0]  be;
`ifdef WRITE_TEST_PORT_EN
  logic         test_wr = 1'b0;
  logic [31:0]  test_addr = 32'h0;
  logic [127:0] test_wr_data = '0;
  logic         wr_finish;
`endif

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  logic [31:0] head = 32'h1000;
  exp_t exp_q[$];

  assign fifo_data = {4{head}};

  always #5 clk = ~clk;

  write_to_ddr3 #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(4)) dut (
    .ddr3_clk(clk), .ddr3_reset_n(rst_n), .frame_start(frame_start),
    .data_fifo_rd_data(fifo_data), .data_fifo_usedw(usedw), .data_fifo_rd(fifo_rd),
    .ddr3_buffer0_offset(off0), .ddr3_buffer1_offset(off1),
    .clear_buffer0(clr0), .clear_buffer1(clr1),
    .buffer0_full(full0), .buffer1_full(full1),
    .ddr3_avl_ready(ready), .ddr3_avl_burstbegin(bb), .ddr3_avl_write_req(wreq),
    .ddr3_avl_size(size), .ddr3_avl_addr(addr), .ddr3_avl_wdata(wdata), .ddr3_avl_be(be)
`ifdef WRITE_TEST_PORT_EN
    , .test_wr(test_wr), .test_addr(test_addr), .test_wr_data(test_wr_data), .wr_finish(wr_finish)
`endif
  );

  // Show-ahead FIFO model: head advances on every pop
  always @(posedge clk) begin
    if (fifo_rd) begin
      head <= head + 32'd1;
      pops <= pops + 1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [25:0] base, input logic [31:0] hh, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = base + 26'(4 * (i / 4));
      e.data = {4{hh + 32'(i)}};
      e.bb   = ((i % 4) == 0);
      e.size = 3'b100;
      e.pop  = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Monitor: every accepted beat is checked against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wreq && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat addr=%0h", addr);
      end else begin
        e = exp_q.pop_front();
        check("beat_addr", 128'(addr), 128'(e.addr));
        check("beat_wdata", wdata, e.data);
        check("beat_ctl", 128'({bb, size, fifo_rd, be}), 128'({e.bb, e.size, e.pop, 16'hFFFF}));
      end
    end else if (rst_n && wreq && !ready) begin
      check("stall_no_pop", 128'(fifo_rd), 128'(0));
    end
  end

  initial begin
    int n;
    int p0;
    logic [31:0] hh;
    logic seen_wr;

    // Reset state
    #23;
    check("rst_wreq", 128'(wreq), 128'(0));
    check("rst_bb", 128'(bb), 128'(0));
    check("rst_size", 128'(size), 128'(0));
    check("rst_pop", 128'(fifo_rd), 128'(0));
    check("rst_addr", 128'(addr), 128'(0));
    check("rst_full", 128'({full0, full1}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Frame 0: straight run into buffer0
    hh = head; p0 = pops;
    push_frame(26'h100, hh, 32);
    pulse_frame();
    n = 0;
    while (!full0 && n < 500) begin tick(); n++; end
    check("f0_full0", 128'(full0), 128'(1));
    check("f0_full1", 128'(full1), 128'(0));
    check("f0_pops", 128'(pops - p0), 128'(32));
    check("f0_queue_empty", 128'(exp_q.size()), 128'(0));

    // Frame 1 into buffer1 with a 3-cycle stall on beat 2 of burst 0
    hh = head; p0 = pops;
    push_frame(26'h200, hh, 32);
    pulse_frame();
    n = 0;
    while (!(wreq && bb) && n < 50) begin tick(); n++; end
    check("f1_first_bb", 128'({wreq, bb}), 128'(2'b11));
    tick();
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_wreq", 128'(wreq), 128'(1));
      check("stall_addr", 128'(addr), 128'(26'h200));
      check("stall_wdata", wdata, {4{hh + 32'd2}});
      check("stall_pop", 128'(fifo_rd), 128'(0));
      tick();
    end
    ready = 1'b1;
    // Clear buffer1 on the same cycle it completes: set must win
    n = 0;
    while (!(wreq && exp_q.size() == 1) && n < 500) begin tick(); n++; end
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check("f1_set_wins", 128'(full1), 128'(1));
    check("f1_full0_kept", 128'(full0), 128'(1));
    check("f1_pops", 128'(pops - p0), 128'(32));
    check("f1_queue_empty", 128'(exp_q.size()), 128'(0));

    // Both buffers full: frame dropped
    p0 = pops; seen_wr = 1'b0;
    pulse_frame();
    for (int i = 0; i < 20; i++) begin
      if (wreq) seen_wr = 1'b1;
      tick();
    end
    check("drop_no_write", 128'(seen_wr), 128'(0));
    check("drop_no_pop", 128'(pops - p0), 128'(0));

    // Release buffer0
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("clr0_full0", 128'(full0), 128'(0));
    check("clr0_full1", 128'(full1), 128'(1));

    // Reset on beat 1 of burst 3
    hh = head;
    push_frame(26'h100, hh, 13);
    pulse_frame();
    n = 0;
    while (!(wreq && !bb && addr == 26'h10C) && n < 500) begin tick(); n++; end
    check("mid_reached", 128'(addr), 128'(26'h10C));
    rst_n = 1'b0;
    #1;
    check("mid_rst_wreq", 128'({wreq, bb, fifo_rd}), 128'(0));
    check("mid_rst_size", 128'(size), 128'(0));
    check("mid_rst_addr", 128'(addr), 128'(0));
    check("mid_rst_flags", 128'({full0, full1}), 128'(0));
    check("mid_queue_empty", 128'(exp_q.size()), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Restart after reset lands at offset0
    hh = head; p0 = pops;
    push_frame(26'h100, hh, 32);
    pulse_frame();
    n = 0;
    while (!full0 && n < 500) begin tick(); n++; end
    check("re_full0", 128'(full0), 128'(1));
    check("re_pops", 128'(pops - p0), 128'(32));
    check("re_queue_empty", 128'(exp_q.size()), 128'(0));

`ifdef WRITE_TEST_PORT_EN
    // Single-beat test write
    begin
      exp_t e;
      e.addr = 26'h55; e.data = {16{8'hA5}}; e.bb = 1'b1; e.size = 3'b001; e.pop = 1'b0;
      exp_q.push_back(e);
    end
    p0 = pops;
    test_addr = 32'h55;
    test_wr_data = {16{8'hA5}};
    test_wr = 1'b1;
    tick();
    test_wr = 1'b0;
    n = 0;
    while (!wr_finish && n < 20) begin tick(); n++; end
    check("test_finish", 128'(wr_finish), 128'(1));
    tick();
    check("test_finish_pulse", 128'(wr_finish), 128'(0));
    check("test_no_pop", 128'(pops - p0), 128'(0));
    check("test_queue_empty", 128'(exp_q.size()), 128'(0));
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
